button_matrix_scanner: RTL and testbench
========================================

BUTTON_MATRIX_SCANNER -- requirements
Module: button_matrix_scanner

Interface
REQ-001 Parameter N, default 8, is the matrix size (N×N switches); 1..8 legal, other values SHALL raise $error at elaboration.
REQ-002 Parameter SETTLE_CYCLES, default 16, is the clocks each column is driven before its sample; must be >= 3, else $error.
REQ-003 Parameter DEBOUNCE_FRAMES, default 4, is the identical consecutive raw frames needed to update cells; must be >= 1, else $error.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  scan enable, synchronous level.
REQ-007 rows_in  input  N  matrix row sense lines, active-low: pulled up, low = switch pressed in the driven column; asynchronous to clk.
REQ-008 cols  output  N  column drive, one-hot active-high; all-zero when not driving.
REQ-009 cells  output  N*N  debounced switch map, 1 = pressed; bit r*N+c is row r, column c.
REQ-010 frame_valid  output  1  one-cycle pulse at the end of every completed scan frame.
REQ-011 changed  output  1  one-cycle pulse, coincident with frame_valid, only when cells was updated to a different value.

Function
REQ-012 rows_in SHALL pass through a 2-flop synchronizer before use; the sampled value is the inverted synchronizer output.
REQ-013 FSM states: IDLE, DRIVE, SAMPLE, UPDATE.
REQ-014 IDLE: cols = 0 and column index = 0; on ena = 1, the FSM SHALL enter DRIVE on the next edge.
REQ-015 DRIVE: cols = one-hot(column index); the FSM SHALL stay exactly SETTLE_CYCLES cycles, with the settle counter running 0..SETTLE_CYCLES-1, then enter SAMPLE.
REQ-016 SAMPLE: cols is still driven for one cycle; the synced, inverted rows SHALL be written into raw[r*N+col] for all r.
REQ-017 SAMPLE exit: if col < N-1, col increments and the FSM returns to DRIVE; if col = N-1, col wraps to 0 and the FSM enters UPDATE.
REQ-018 UPDATE (1 cycle, cols = 0): if raw == prev_raw, stable_cnt SHALL increment, saturating at DEBOUNCE_FRAMES-1; otherwise stable_cnt clears to 0. In both cases prev_raw <= raw.
REQ-019 UPDATE: when the post-update stable_cnt equals DEBOUNCE_FRAMES-1, cells <= raw. changed pulses iff the new value differs from the old cells. frame_valid pulses on every UPDATE exit.
REQ-020 UPDATE exit: to DRIVE if ena = 1, else to IDLE.
REQ-021 Frame period SHALL be N*(SETTLE_CYCLES+1)+1 cycles: 137 for the defaults.
REQ-022 ena = 0 in DRIVE or SAMPLE SHALL force IDLE on the next edge. The partial raw frame is discarded, col resets to 0, and cells and stable_cnt are held. No frame_valid is issued.
REQ-023 Only the column under scan is driven; overlap of two columns SHALL never occur, including across the wrap from column N-1 to 0.
REQ-024 With DEBOUNCE_FRAMES = 1, cells SHALL follow raw every frame.

Reset
REQ-025 rst_n low SHALL asynchronously set: state IDLE, col 0, settle counter 0, cols 0, cells 0, raw 0, prev_raw 0, stable_cnt 0, synchronizer flops all-ones (released), frame_valid 0, changed 0.
REQ-026 Reset asserted mid-frame SHALL abort the scan with no pulse; after release, scanning restarts from column 0 when ena = 1.

Structure
REQ-027 Package matrix_pkg SHALL hold the scan_state_t enum (IDLE, DRIVE, SAMPLE, UPDATE) and the MAX_N = 8 constant, shared with the LED driver path.
REQ-028 One sub-module, synchronizer (parameter WIDTH, 2 stages, clk/rst_n), SHALL hold the rows_in sync; all other logic stays in button_matrix_scanner.

Verification
REQ-029 Case: defaults, ena = 1, no key pressed. Required: cols steps 0x01, 0x02 … 0x80, each held 17 cycles; frame_valid every 137 cycles; cells = 0; changed never pulses.
REQ-030 Case: switch row 2 / col 5 held down (model pulls rows_in[2] low while cols[5] = 1). Required: after the 4th identical frame, cells[21] = 1 with a changed pulse; cells stays 0 before that.
REQ-031 Case: the switch bounces on alternate frames for 10 frames, then is held. Required: cells unchanged during bouncing; updates only after 4 consecutive identical frames.
REQ-032 Case: ena dropped during DRIVE of column 3. Required: cols = 0 next cycle; no frame_valid; cells held. ena re-raised: scan restarts at cols = 0x01.
REQ-033 Case: rst_n pulsed low mid-frame with cells = 0x…0020_0000. Required: cells, cols, frame_valid and changed go to 0 immediately, without a clock edge.
REQ-034 Case: N = 4, SETTLE_CYCLES = 3, DEBOUNCE_FRAMES = 1, every switch pressed. Required: frame period 17 cycles; cells = 0xFFFF after the first frame_valid; cols never has 2 bits set.

Source files
------------

// File: rtl/button_matrix_scanner_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
// Types and constants shared by the switch-matrix scanner and the LED matrix
// driver path.
//   MAX_N        : largest supported matrix edge (N x N switches)
//   scan_state_t : column-scan sequencer states
// ----------------------------------------------------------------------------
package matrix_pkg;

    localparam int MAX_N = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        UPDATE = 2'd3
    } scan_state_t;

endpackage : matrix_pkg

// File: rtl/button_matrix_scanner_synchronizer.sv
// ----------------------------------------------------------------------------
// synchronizer
// Two-stage flop synchronizer for a bus of independent level signals.
// The flops reset to all-ones, which is the released (pulled-up) level of the
// active-low row sense lines.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bus
//   q     : synchronized output bus
// ----------------------------------------------------------------------------
module synchronizer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Two flop stages; the first may go metastable, the second resolves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= {WIDTH{1'b1}};
            q      <= {WIDTH{1'b1}};
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule : synchronizer

// File: rtl/button_matrix_scanner.sv
// ----------------------------------------------------------------------------
// button_matrix_scanner
// Scans an N x N switch matrix one column at a time, assembles a raw frame of
// switch states and debounces it frame-by-frame: the published map only
// changes after DEBOUNCE_FRAMES identical consecutive raw frames.
//   clk         : sole clock, rising edge
//   rst_n       : asynchronous active-low reset
//   ena         : scan enable (level)
//   rows_in     : row sense lines, active-low, asynchronous to clk
//   cols        : column drive, one-hot active-high, zero when idle
//   cells       : debounced switch map, bit r*N+c = row r / column c, 1 = pressed
//   frame_valid : one-cycle pulse at the end of each completed frame
//   changed     : one-cycle pulse with frame_valid when cells took a new value
// ----------------------------------------------------------------------------
module button_matrix_scanner
    import matrix_pkg::*;
#(
    parameter int N               = 8,
    parameter int SETTLE_CYCLES   = 16,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ena,
    input  logic [N-1:0]   rows_in,
    output logic [N-1:0]   cols,
    output logic [N*N-1:0] cells,
    output logic           frame_valid,
    output logic           changed
);

    // Parameter legality is checked while elaborating.
    if (N < 1 || N > MAX_N) begin : g_bad_n
        $error("button_matrix_scanner: N=%0d outside 1..%0d", N, MAX_N);
    end
    if (SETTLE_CYCLES < 3) begin : g_bad_settle
        $error("button_matrix_scanner: SETTLE_CYCLES=%0d must be >= 3", SETTLE_CYCLES);
    end
    if (DEBOUNCE_FRAMES < 1) begin : g_bad_debounce
        $error("button_matrix_scanner: DEBOUNCE_FRAMES=%0d must be >= 1", DEBOUNCE_FRAMES);
    end

    localparam int CLW = (N > 1) ? $clog2(N) : 1;
    localparam int SW  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int CW  = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;

    localparam logic [CLW-1:0] COL_LAST    = CLW'(N - 1);
    localparam logic [SW-1:0]  SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0]  STABLE_MAX  = CW'(DEBOUNCE_FRAMES - 1);
    localparam logic [N-1:0]   FIRST_COL   = N'(1'b1);

    scan_state_t      state_r;
    logic [CLW-1:0]   col_r;
    logic [SW-1:0]    settle_r;
    logic [N*N-1:0]   raw_r;
    logic [N*N-1:0]   prev_raw_r;
    logic [CW-1:0]    stable_r;

    logic [N-1:0]     row_sync_s;
    logic [N*N-1:0]   raw_sampled_s;
    logic [CLW-1:0]   col_next_s;
    logic [N-1:0]     col_next_onehot_s;
    logic [CW-1:0]    stable_next_s;
    logic             cells_load_s;

    synchronizer #(
        .WIDTH (N)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rows_in),
        .q     (row_sync_s)
    );

    // Raw frame with the current column's sensed rows merged in (low = pressed).
    always_comb begin
        raw_sampled_s = raw_r;
        for (int r = 0; r < N; r++) begin
            raw_sampled_s[r*N + int'(col_r)] = ~row_sync_s[r];
        end
    end

    // Next column index and its drive pattern; only used when col_r < N-1.
    always_comb begin
        if (col_r == COL_LAST) begin
            col_next_s = {CLW{1'b0}};
        end else begin
            col_next_s = col_r + 1'b1;
        end
        col_next_onehot_s = FIRST_COL << col_next_s;
    end

    // Debounce counter update and cells load decision for the UPDATE cycle.
    always_comb begin
        if (raw_r == prev_raw_r) begin
            if (stable_r == STABLE_MAX) begin
                stable_next_s = STABLE_MAX;
            end else begin
                stable_next_s = stable_r + 1'b1;
            end
        end else begin
            stable_next_s = {CW{1'b0}};
        end
        cells_load_s = (stable_next_s == STABLE_MAX);
    end

    // Scan sequencer with registered column drive, map and pulses.
    // Dropping ena mid-frame leaves a partially written raw_r behind; every
    // column is re-sampled before the next UPDATE, so those bits never reach
    // the debounce compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            col_r       <= {CLW{1'b0}};
            settle_r    <= {SW{1'b0}};
            cols        <= {N{1'b0}};
            cells       <= {(N*N){1'b0}};
            raw_r       <= {(N*N){1'b0}};
            prev_raw_r  <= {(N*N){1'b0}};
            stable_r    <= {CW{1'b0}};
            frame_valid <= 1'b0;
            changed     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            case (state_r)
                IDLE: begin
                    col_r    <= {CLW{1'b0}};
                    settle_r <= {SW{1'b0}};
                    if (ena) begin
                        state_r <= DRIVE;
                        cols    <= FIRST_COL;
                    end else begin
                        state_r <= IDLE;
                        cols    <= {N{1'b0}};
                    end
                end
                DRIVE: begin
                    if (!ena) begin
                        state_r  <= IDLE;
                        col_r    <= {CLW{1'b0}};
                        settle_r <= {SW{1'b0}};
                        cols     <= {N{1'b0}};
                    end else if (settle_r == SETTLE_LAST) begin
                        state_r  <= SAMPLE;
                        settle_r <= {SW{1'b0}};
                    end else begin
                        settle_r <= settle_r + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (!ena) begin
                        state_r  <= IDLE;
                        col_r    <= {CLW{1'b0}};
                        settle_r <= {SW{1'b0}};
                        cols     <= {N{1'b0}};
                    end else begin
                        raw_r <= raw_sampled_s;
                        // Going straight from one column to the next never
                        // overlaps; the last column releases all drives.
                        if (col_r == COL_LAST) begin
                            state_r <= UPDATE;
                            col_r   <= {CLW{1'b0}};
                            cols    <= {N{1'b0}};
                        end else begin
                            state_r <= DRIVE;
                            col_r   <= col_next_s;
                            cols    <= col_next_onehot_s;
                        end
                    end
                end
                UPDATE: begin
                    prev_raw_r  <= raw_r;
                    stable_r    <= stable_next_s;
                    frame_valid <= 1'b1;
                    if (cells_load_s) begin
                        cells   <= raw_r;
                        changed <= (raw_r != cells);
                    end else begin
                        changed <= 1'b0;
                    end
                    if (ena) begin
                        state_r <= DRIVE;
                        cols    <= FIRST_COL;
                    end else begin
                        state_r <= IDLE;
                        cols    <= {N{1'b0}};
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    col_r    <= {CLW{1'b0}};
                    settle_r <= {SW{1'b0}};
                    cols     <= {N{1'b0}};
                end
            endcase
        end
    end

endmodule : button_matrix_scanner

// File: tb/tb_button_matrix_scanner.sv
// ----------------------------------------------------------------------------
// tb_button_matrix_scanner
// Self-checking bench: a default 8x8 scanner (key row 2 / column 5 modelled
// as a switch that pulls its row low while its column is driven) and a 4x4
// fast-settle scanner with every switch pressed.
// ----------------------------------------------------------------------------
module tb_button_matrix_scanner;

    localparam logic [63:0] KEY = 64'h0000_0000_0020_0000;  // bit 21

    logic        clk;
    logic        rst_n;
    logic        ena_a;
    logic        ena_b;
    logic [7:0]  rows_a;
    logic [7:0]  cols_a;
    logic [63:0] cells_a;
    logic        fv_a;
    logic        chg_a;
    logic [3:0]  rows_b;
    logic [3:0]  cols_b;
    logic [15:0] cells_b;
    logic        fv_b;
    logic        chg_b;

    logic        key_down;
    logic [15:0] press_b;

    int errors = 0;
    int checks = 0;
    int ovl_a = 0;
    int ovl_b = 0;
    int stray = 0;

    typedef struct {
        logic        press;
        logic [63:0] exp_cells;
        logic        exp_changed;
    } frame_rec_t;

    frame_rec_t tbl [17];

    button_matrix_scanner dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena_a),
        .rows_in     (rows_a),
        .cols        (cols_a),
        .cells       (cells_a),
        .frame_valid (fv_a),
        .changed     (chg_a)
    );

    button_matrix_scanner #(
        .N               (4),
        .SETTLE_CYCLES   (3),
        .DEBOUNCE_FRAMES (1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena_b),
        .rows_in     (rows_b),
        .cols        (cols_b),
        .cells       (cells_b),
        .frame_valid (fv_b),
        .changed     (chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix models: a pressed switch pulls its row low while its column is driven.
    always_comb begin
        rows_a = 8'hFF;
        if (key_down && cols_a[5]) begin
            rows_a[2] = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            rows_b[r] = ~|(press_b[r*4 +: 4] & cols_b);
        end
    end

    // Continuous monitors: column overlap and changed without frame_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if ($countones(cols_a) > 1) ovl_a++;
            if ($countones(cols_b) > 1) ovl_b++;
            if ((chg_a && !fv_a) || (chg_b && !fv_b)) stray++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts negedges until the selected frame_valid is seen, bounded by limit.
    task automatic wait_fv(input bit use_b, input int limit, output int n);
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            hit = use_b ? fv_b : fv_a;
        end
    endtask

    initial begin
        int n;
        int bad;
        int pulses;
        logic [7:0] exp_col;

        // Frame 1 is consumed by the column-walk check; table starts at frame 2.
        tbl[0]  = '{1'b0, 64'd0, 1'b0};
        tbl[1]  = '{1'b0, 64'd0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            tbl[2+i] = '{((i % 2) == 0), 64'd0, 1'b0};   // bounce 1,0,1,0...
        end
        tbl[12] = '{1'b1, 64'd0, 1'b0};
        tbl[13] = '{1'b1, 64'd0, 1'b0};
        tbl[14] = '{1'b1, 64'd0, 1'b0};
        tbl[15] = '{1'b1, KEY,   1'b1};                   // 4th identical frame
        tbl[16] = '{1'b1, KEY,   1'b0};

        rst_n    = 1'b0;
        ena_a    = 1'b0;
        ena_b    = 1'b0;
        key_down = 1'b0;
        press_b  = 16'hFFFF;
        #1;
        check("reset_cols_a",  {56'd0, cols_a}, 64'd0);
        check("reset_cells_a", cells_a, 64'd0);
        check("reset_fv_chg",  {62'd0, fv_a, chg_a}, 64'd0);
        check("reset_cells_b", {48'd0, cells_b}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_cols_a", {56'd0, cols_a}, 64'd0);

        // Column walk: each column held 17 cycles, then one all-zero UPDATE cycle.
        ena_a = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bad = 0;
            exp_col = 8'h01 << c;
            for (int k = 0; k < 17; k++) begin
                @(negedge clk);
                if (cols_a !== exp_col || fv_a !== 1'b0) bad++;
            end
            check($sformatf("col_walk_%0d_bad_cycles", c), 64'(bad), 64'd0);
        end
        @(negedge clk);
        check("update_cycle_cols", {55'd0, fv_a, cols_a}, 64'd0);
        @(negedge clk);
        check("frame1_fv_cols", {55'd0, fv_a, cols_a}, {55'd0, 1'b1, 8'h01});
        check("frame1_cells_chg", {cells_a[62:0], chg_a}, 64'd0);

        // Debounce table: one record per frame.
        for (int i = 0; i < 17; i++) begin
            key_down = tbl[i].press;
            wait_fv(1'b0, 400, n);
            check($sformatf("frame_%0d_period", i + 2), 64'(n), 64'd137);
            check($sformatf("frame_%0d_cells", i + 2), cells_a, tbl[i].exp_cells);
            check($sformatf("frame_%0d_changed", i + 2), {63'd0, chg_a}, {63'd0, tbl[i].exp_changed});
        end

        // Drop ena while column 3 is driven.
        n = 0;
        while (cols_a !== 8'h08 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_col3", {56'd0, cols_a}, 64'h08);
        ena_a = 1'b0;
        @(negedge clk);
        check("abort_cols", {56'd0, cols_a}, 64'd0);
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (fv_a || chg_a || cols_a != 8'h00) pulses++;
        end
        check("abort_quiet", 64'(pulses), 64'd0);
        check("abort_cells_held", cells_a, KEY);
        ena_a = 1'b1;
        @(negedge clk);
        check("restart_cols", {56'd0, cols_a}, 64'h01);
        wait_fv(1'b0, 400, n);
        check("restart_period", 64'(n), 64'd137);
        check("restart_cells", cells_a, KEY);
        check("restart_changed", {63'd0, chg_a}, 64'd0);

        // Asynchronous reset mid-frame, between clock edges.
        repeat (40) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_cells", cells_a, 64'd0);
        check("async_rst_cols", {56'd0, cols_a}, 64'd0);
        check("async_rst_fv_chg", {62'd0, fv_a, chg_a}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_cols", {56'd0, cols_a}, 64'h01);
        ena_a = 1'b0;

        // 4x4, SETTLE_CYCLES=3, DEBOUNCE_FRAMES=1, all switches pressed.
        ena_b = 1'b1;
        wait_fv(1'b1, 100, n);
        check("b_first_fv_seen", {63'd0, fv_b}, 64'd1);
        check("b_first_cells", {48'd0, cells_b}, 64'hFFFF);
        check("b_first_changed", {63'd0, chg_b}, 64'd1);
        wait_fv(1'b1, 100, n);
        check("b_period", 64'(n), 64'd17);
        check("b_second_cells", {48'd0, cells_b}, 64'hFFFF);
        check("b_second_changed", {63'd0, chg_b}, 64'd0);
        ena_b = 1'b0;
        repeat (5) @(negedge clk);

        check("overlap_a", 64'(ovl_a), 64'd0);
        check("overlap_b", 64'(ovl_b), 64'd0);
        check("stray_changed", 64'(stray), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_button_matrix_scanner
